spart: RTL and testbench
========================

# spart

Special-purpose asynchronous receiver/transmitter sitting directly downstream of the processor-side driver FSM: it decodes the `iocs`/`iorw`/`ioaddr`/`databus` register interface, serialises writes onto `txd`, deserialises `rxd`, and reports `rda`/`tbr` back to the driver. It contains a programmable baud-rate generator, an 8N1 transmitter and a 16x-oversampled receiver.

## Interface
- `RESET_DIV`, 16'd325, divisor buffer reset value (9600 baud at 50 MHz with 16x oversampling)
- `clk` input 1 system clock, all logic on rising edge
- `rst` input 1 one clock; reset is synchronous and active-high
- `iocs` input 1 chip select
- `iorw` input 1 1 = read (SPART drives bus), 0 = write
- `ioaddr` input 2 register select
- `databus` inout 8 bidirectional data bus
- `rda` output 1 receive data available
- `tbr` output 1 transmit buffer ready
- `txd` output 1 serial out, idle high
- `rxd` input 1 serial in, asynchronous

## Operation
- Register map: 00 write = Tx buffer, read = Rx buffer; 01 read = status {4'b0, overrun, frame_err, tbr, rda}, write ignored; 10 = DBL, 11 = DBH (write-only, reads return 8'h00).
- Bus drive: `databus` driven only when `iocs & iorw`; otherwise high-Z. Read data is combinational from registers.
- Baud generator: down-counter loaded with {DBH,DBL}; emits one-cycle `en` when it reaches 0, then reloads. Enable period = DIV+1 clocks; DIV=0 gives `en` every cycle. Any DB write reloads the counter on the same edge.
- Transmitter FSM: TX_IDLE -> TX_SHIFT -> TX_IDLE. Write to 00 with `tbr`=1 loads {1,data,0} into 10-bit shift register; `tbr` low from next cycle. Writes with `tbr`=0 are dropped. Each bit held 16 `en` pulses, LSB first, then stop bit; `tbr` rises the cycle after stop bit completes.
- Receiver FSM: RX_IDLE, RX_START, RX_DATA, RX_STOP. `rxd` passes a 2-flop synchroniser. RX_IDLE: synced low on an `en` -> RX_START. RX_START: after 8 `en`, sample; low -> RX_DATA, high -> RX_IDLE (glitch rejected). RX_DATA: sample every 16 `en`, 8 bits LSB first. RX_STOP: sample after 16 `en`; high -> load Rx buffer, `rda`=1; low -> set `frame_err`, discard byte. Either -> RX_IDLE.
- Read of 00 clears `rda` at the next edge. Read of 01 clears `overrun` and `frame_err` at the next edge.
- Byte completes while `rda`=1: buffer overwritten, `overrun` set.

## Timing
- Reset values: `txd`=1, `tbr`=1, `rda`=0, `overrun`=0, `frame_err`=0, DB=`RESET_DIV`, Rx buffer 8'h00, both FSMs idle, `databus` high-Z. Reset mid-frame aborts immediately; `txd`=1 the cycle after reset asserts.
- Write latency: `txd` goes low the cycle after the write edge; first (start) bit may be shorter than others by up to DIV clocks (aligned to free-running `en`); remaining bits exactly 16·(DIV+1) clocks.
- Receive latency: `rda` rises 2 (sync) + ≤ one bit period after the stop-bit midpoint.
- Simultaneous: Rx-buffer read on the same edge a new byte lands -> new byte wins, `rda` stays 1, `overrun` not set. Status read on the same edge an error sets -> flag stays set.
- DB write during active frame takes effect from the next `en`; no frame abort.

## Structure
- `spart_pkg`: address constants (ADDR_BUF, ADDR_STATUS, ADDR_DBL, ADDR_DBH), OVERSAMPLE=16, `tx_state_t`, `rx_state_t` enums.
- Sub-module `spart_rx` (synchroniser, receiver FSM, bit/sample counters, error flags); baud generator, transmitter and bus decode stay in top.

## Test plan
- Reset: assert `rst` 2 cycles -> `txd`=1, `tbr`=1, `rda`=0, bus high-Z, status read = 8'h02.
- TX: DIV=0, write 8'hA5 to 00 -> `txd` sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 clocks; `tbr` low throughout, high after; second write while `tbr`=0 dropped.
- RX loopback: DIV=3, tie `txd` to `rxd`, send 8'h3C -> `rda`=1, read 00 returns 8'h3C, `rda`=0 next cycle.
- Errors: drive frame with stop bit 0 -> status bit 2 set, `rda`=0; 2-clock low glitch on idle `rxd` -> no reception; two bytes without reading -> second byte readable, status bit 3 set, cleared after status read.
- DB write: write DBL=8'h07, DBH=8'h00 -> `en` period 8 clocks, bit period 128 clocks.
- Reset mid-transmit at bit 4 -> `txd`=1 next cycle, `tbr`=1, subsequent write transmits cleanly.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared constants and state encodings for the SPART register interface,
// baud generator, transmitter and receiver.
package spart_pkg;

    localparam logic [1:0] ADDR_BUF    = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DBL    = 2'b10;
    localparam logic [1:0] ADDR_DBH    = 2'b11;

    localparam int OVERSAMPLE = 16;
    localparam int HALF_BIT   = OVERSAMPLE / 2;

    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/spart_rx.sv
// 16x-oversampled 8N1 receiver: input synchroniser, framing FSM, receive
// buffer and the sticky overrun / framing-error flags.
module spart_rx
    import spart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       rxd_i,
    input  logic       rd_buf_i,
    input  logic       rd_status_i,
    output logic [7:0] data_o,
    output logic       rda_o,
    output logic       overrun_o,
    output logic       frame_err_o
);

    logic      sync1_q, sync2_q;
    rx_state_t state_q;
    logic [3:0] en_cnt_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q, buf_q;
    logic       rda_q, ovr_q, ferr_q;
    logic       mid_en, last_en;

    assign mid_en  = en_i && (en_cnt_q == 4'(HALF_BIT - 1));
    assign last_en = en_i && (en_cnt_q == 4'(OVERSAMPLE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= RX_IDLE;
            en_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            buf_q     <= '0;
            rda_q     <= 1'b0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
            // Clears come first so a flag set on the same edge wins.
            if (rd_buf_i) rda_q <= 1'b0;
            if (rd_status_i) begin
                ovr_q  <= 1'b0;
                ferr_q <= 1'b0;
            end
            if (en_i) en_cnt_q <= en_cnt_q + 4'd1;
            case (state_q)
                RX_IDLE: begin
                    if (en_i && !sync2_q) begin
                        state_q  <= RX_START;
                        en_cnt_q <= '0;
                    end
                end
                RX_START: begin
                    if (mid_en) begin
                        en_cnt_q  <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= sync2_q ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (last_en) begin
                        shift_q   <= {sync2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (last_en) begin
                        state_q <= RX_IDLE;
                        if (sync2_q) begin
                            buf_q <= shift_q;
                            rda_q <= 1'b1;
                            // A read landing on the same edge consumes the old byte.
                            if (rda_q && !rd_buf_i) ovr_q <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign data_o      = buf_q;
    assign rda_o       = rda_q;
    assign overrun_o   = ovr_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/spart.sv
// SPART top: register decode and bus drive, programmable baud generator,
// 8N1 transmitter, and the receiver sub-block.
module spart
    import spart_pkg::*;
#(
    parameter logic [15:0] RESET_DIV = 16'd325
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    logic wr_buf, wr_dbl, wr_dbh, rd_en, rd_buf, rd_status;
    logic [15:0] db_q, db_d, cnt_q, cnt_d;
    logic        baud_en;
    logic [7:0]  rx_data, rd_data;
    logic        overrun, frame_err;

    tx_state_t  tx_state_q;
    logic [9:0] tx_sh_q;
    logic [3:0] tx_en_cnt_q, tx_bit_q;
    logic       tbr_q;

    assign rd_en     = iocs & iorw;
    assign rd_buf    = rd_en && (ioaddr == ADDR_BUF);
    assign rd_status = rd_en && (ioaddr == ADDR_STATUS);
    assign wr_buf    = iocs && !iorw && (ioaddr == ADDR_BUF);
    assign wr_dbl    = iocs && !iorw && (ioaddr == ADDR_DBL);
    assign wr_dbh    = iocs && !iorw && (ioaddr == ADDR_DBH);

    assign baud_en = (cnt_q == 16'd0);

    // A divisor write restarts the counter from the new value at once.
    always_comb begin
        db_d = db_q;
        if (wr_dbl) db_d[7:0]  = databus;
        if (wr_dbh) db_d[15:8] = databus;
        cnt_d = cnt_q - 16'd1;
        if (wr_dbl || wr_dbh) cnt_d = db_d;
        else if (baud_en)     cnt_d = db_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_q  <= RESET_DIV;
            cnt_q <= RESET_DIV;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    // Shift register refills with 1s so txd idles high after the stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            tx_sh_q     <= '1;
            tx_en_cnt_q <= '0;
            tx_bit_q    <= '0;
            tbr_q       <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (wr_buf) begin
                        tx_sh_q     <= {1'b1, databus, 1'b0};
                        tx_state_q  <= TX_SHIFT;
                        tx_en_cnt_q <= '0;
                        tx_bit_q    <= '0;
                        tbr_q       <= 1'b0;
                    end
                end
                TX_SHIFT: begin
                    if (baud_en) begin
                        tx_en_cnt_q <= tx_en_cnt_q + 4'd1;
                        if (tx_en_cnt_q == 4'(OVERSAMPLE - 1)) begin
                            tx_sh_q <= {1'b1, tx_sh_q[9:1]};
                            if (tx_bit_q == 4'd9) begin
                                tx_state_q <= TX_IDLE;
                                tbr_q      <= 1'b1;
                            end else begin
                                tx_bit_q <= tx_bit_q + 4'd1;
                            end
                        end
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    spart_rx u_rx (
        .clk         (clk),
        .rst         (rst),
        .en_i        (baud_en),
        .rxd_i       (rxd),
        .rd_buf_i    (rd_buf),
        .rd_status_i (rd_status),
        .data_o      (rx_data),
        .rda_o       (rda),
        .overrun_o   (overrun),
        .frame_err_o (frame_err)
    );

    always_comb begin
        rd_data = 8'h00;
        case (ioaddr)
            ADDR_BUF:    rd_data = rx_data;
            ADDR_STATUS: rd_data = {4'b0000, overrun, frame_err, tbr_q, rda};
            default:     rd_data = 8'h00;
        endcase
    end

    assign databus = rd_en ? rd_data : 8'hzz;
    assign tbr     = tbr_q;
    assign txd     = tx_sh_q[0];

endmodule

// File: tb/tb_spart.sv
// Directed bench for spart: reset, transmit framing, loopback receive,
// error flags, divisor programming and reset during a frame.
module tb_spart;
    import spart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iocs = 1'b0, iorw = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    logic       tb_oe = 1'b0;
    logic [7:0] tb_drv = 8'h00;
    logic       rxd_drv = 1'b1, loopback = 1'b0;
    wire  [7:0] databus;
    logic       rda, tbr, txd, rxd;
    int         n_cmp = 0, n_bad = 0;

    assign databus = tb_oe ? tb_drv : 8'hzz;
    assign rxd     = loopback ? txd : rxd_drv;

    always #5 clk = ~clk;

    spart dut (
        .clk     (clk),
        .rst     (rst),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr),
        .txd     (txd),
        .rxd     (rxd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_drv = d; tb_oe = 1'b1;
        tick();
        iocs = 1'b0; tb_oe = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #1;
        d = databus;
        tick();
        iocs = 1'b0; iorw = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        int k;
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL reset_txd: got %b want 1", txd); end
        n_cmp++; if (tbr !== 1'b1) begin n_bad++; $display("FAIL reset_tbr: got %b want 1", tbr); end
        n_cmp++; if (rda !== 1'b0) begin n_bad++; $display("FAIL reset_rda: got %b want 0", rda); end
        rst = 1'b0;
        iorw = 1'b1; ioaddr = ADDR_STATUS; tb_drv = 8'h00; tb_oe = 1'b1;
        #1;
        n_cmp++; if (databus !== 8'h00) begin n_bad++; $display("FAIL bus_hiz: got %h want 00", databus); end
        tick();
        tb_oe = 1'b0; iorw = 1'b0;
        bus_read(ADDR_STATUS, d);
        n_cmp++; if (d !== 8'h02) begin n_bad++; $display("FAIL reset_status: got %h want 02", d); end
        bus_read(ADDR_BUF, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_rxbuf: got %h want 00", d); end
        bus_read(ADDR_DBH, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL dbh_read: got %h want 00", d); end
        k = 0;
        while (!dut.baud_en && k < 400) begin tick(); k++; end
        k = 0;
        do begin tick(); k++; end while (!dut.baud_en && k < 400);
        n_cmp++; if (k != 326) begin n_bad++; $display("FAIL reset_en_period: got %0d want 326", k); end
    endtask

    task automatic test_tx();
        logic [9:0] fr;
        fr = {1'b1, 8'hA5, 1'b0};
        bus_write(ADDR_DBL, 8'h00);
        bus_write(ADDR_DBH, 8'h00);
        n_cmp++; if (tbr !== 1'b1) begin n_bad++; $display("FAIL tx_tbr_pre: got %b want 1", tbr); end
        bus_write(ADDR_BUF, 8'hA5);
        for (int i = 0; i <= 160; i++) begin
            if (i == 0 || i == 15 || i == 16 || (i % 16 == 8 && i < 160)) begin
                n_cmp++; if (txd !== fr[i/16]) begin n_bad++; $display("FAIL tx_bit@%0d: got %b want %b", i, txd, fr[i/16]); end
            end
            if (i == 0 || i == 159) begin
                n_cmp++; if (tbr !== 1'b0) begin n_bad++; $display("FAIL tx_tbr_busy@%0d: got %b want 0", i, tbr); end
            end
            if (i == 40) begin iocs = 1'b1; iorw = 1'b0; ioaddr = ADDR_BUF; tb_drv = 8'hFF; tb_oe = 1'b1; end
            if (i == 41) begin iocs = 1'b0; tb_oe = 1'b0; end
            if (i == 160) begin
                n_cmp++; if (tbr !== 1'b1) begin n_bad++; $display("FAIL tx_tbr_done: got %b want 1", tbr); end
                n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL tx_idle: got %b want 1", txd); end
            end
            if (i < 160) tick();
        end
    endtask

    task automatic test_rx_loopback();
        logic [7:0] d;
        int k;
        bus_write(ADDR_DBL, 8'h03);
        loopback = 1'b1;
        bus_write(ADDR_BUF, 8'h3C);
        k = 0;
        while (!rda && k < 1500) begin tick(); k++; end
        n_cmp++; if (rda !== 1'b1) begin n_bad++; $display("FAIL rx_rda_timeout: got %b want 1", rda); end
        bus_read(ADDR_BUF, d);
        n_cmp++; if (d !== 8'h3C) begin n_bad++; $display("FAIL rx_data: got %h want 3c", d); end
        n_cmp++; if (rda !== 1'b0) begin n_bad++; $display("FAIL rx_rda_clear: got %b want 0", rda); end
        k = 0;
        while (!tbr && k < 1000) begin tick(); k++; end
        loopback = 1'b0;
    endtask

    task automatic test_errors();
        logic [9:0] fr;
        logic [7:0] d;
        int k;
        fr = {1'b0, 8'h81, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rxd_drv = fr[b];
            repeat (64) tick();
        end
        rxd_drv = 1'b1;
        repeat (200) tick();
        n_cmp++; if (rda !== 1'b0) begin n_bad++; $display("FAIL ferr_rda: got %b want 0", rda); end
        bus_read(ADDR_STATUS, d);
        n_cmp++; if (d !== 8'h06) begin n_bad++; $display("FAIL ferr_status: got %h want 06", d); end
        bus_read(ADDR_STATUS, d);
        n_cmp++; if (d !== 8'h02) begin n_bad++; $display("FAIL ferr_cleared: got %h want 02", d); end

        rxd_drv = 1'b0; tick(); tick(); rxd_drv = 1'b1;
        repeat (300) tick();
        n_cmp++; if (rda !== 1'b0) begin n_bad++; $display("FAIL glitch_rda: got %b want 0", rda); end
        bus_read(ADDR_STATUS, d);
        n_cmp++; if (d !== 8'h02) begin n_bad++; $display("FAIL glitch_status: got %h want 02", d); end

        loopback = 1'b1;
        bus_write(ADDR_BUF, 8'h11);
        k = 0;
        while (!tbr && k < 1000) begin tick(); k++; end
        bus_write(ADDR_BUF, 8'h22);
        k = 0;
        while (!tbr && k < 1000) begin tick(); k++; end
        n_cmp++; if (tbr !== 1'b1) begin n_bad++; $display("FAIL ovr_tx_timeout: got %b want 1", tbr); end
        loopback = 1'b0;
        bus_read(ADDR_STATUS, d);
        n_cmp++; if (d !== 8'h0B) begin n_bad++; $display("FAIL ovr_status: got %h want 0b", d); end
        bus_read(ADDR_BUF, d);
        n_cmp++; if (d !== 8'h22) begin n_bad++; $display("FAIL ovr_data: got %h want 22", d); end
        bus_read(ADDR_STATUS, d);
        n_cmp++; if (d !== 8'h02) begin n_bad++; $display("FAIL ovr_cleared: got %h want 02", d); end
    endtask

    task automatic test_db_write();
        int k, n;
        bus_write(ADDR_DBL, 8'h07);
        bus_write(ADDR_DBH, 8'h00);
        k = 0;
        while (!dut.baud_en && k < 20) begin tick(); k++; end
        k = 0;
        do begin tick(); k++; end while (!dut.baud_en && k < 20);
        n_cmp++; if (k != 8) begin n_bad++; $display("FAIL db_en_period: got %0d want 8", k); end
        bus_write(ADDR_BUF, 8'h55);
        k = 0;
        while (txd !== 1'b1 && k < 300) begin tick(); k++; end
        n = 0;
        while (txd !== 1'b0 && n < 300) begin tick(); n++; end
        n_cmp++; if (n != 128) begin n_bad++; $display("FAIL db_bit_period_a: got %0d want 128", n); end
        n = 0;
        while (txd !== 1'b1 && n < 300) begin tick(); n++; end
        n_cmp++; if (n != 128) begin n_bad++; $display("FAIL db_bit_period_b: got %0d want 128", n); end
        k = 0;
        while (!tbr && k < 2000) begin tick(); k++; end
        n_cmp++; if (tbr !== 1'b1) begin n_bad++; $display("FAIL db_tx_timeout: got %b want 1", tbr); end
    endtask

    task automatic test_reset_mid_tx();
        logic [9:0] fr;
        bus_write(ADDR_DBL, 8'h00);
        bus_write(ADDR_BUF, 8'hA5);
        repeat (72) tick();
        n_cmp++; if (txd !== 1'b0) begin n_bad++; $display("FAIL midtx_bit4: got %b want 0", txd); end
        rst = 1'b1;
        tick();
        n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL midtx_rst_txd: got %b want 1", txd); end
        n_cmp++; if (tbr !== 1'b1) begin n_bad++; $display("FAIL midtx_rst_tbr: got %b want 1", tbr); end
        rst = 1'b0;
        bus_write(ADDR_DBL, 8'h00);
        bus_write(ADDR_DBH, 8'h00);
        fr = {1'b1, 8'h5A, 1'b0};
        bus_write(ADDR_BUF, 8'h5A);
        for (int i = 0; i <= 160; i++) begin
            if (i % 16 == 8 && i < 160) begin
                n_cmp++; if (txd !== fr[i/16]) begin n_bad++; $display("FAIL retx_bit@%0d: got %b want %b", i, txd, fr[i/16]); end
            end
            if (i == 160) begin
                n_cmp++; if (tbr !== 1'b1) begin n_bad++; $display("FAIL retx_tbr: got %b want 1", tbr); end
            end
            if (i < 160) tick();
        end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx_loopback();
        test_errors();
        test_db_write();
        test_reset_mid_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
